// File: rtl/bp_cfg_loader_pkg.sv
// Shared types and constants for the config-bus boot loader: cfg register map,
// uncached memory message format and the loader/issue state encodings.
package bp_cfg_loader_pkg;

  localparam int unsigned paddr_width_gp     = 40;
  localparam int unsigned vaddr_width_gp     = 39;
  localparam int unsigned cce_pc_width_gp    = 8;
  localparam int unsigned cce_instr_width_gp = 32;
  localparam int unsigned cce_data_width_gp  = 64;

  localparam logic [15:0] bp_cfg_ucode_base_gp       = 16'h8000;
  localparam logic [15:0] bp_cfg_reg_freeze_gp       = 16'h0008;
  localparam logic [15:0] bp_cfg_reg_npc_gp          = 16'h0010;
  localparam logic [15:0] bp_cfg_reg_icache_mode_gp  = 16'h0022;
  localparam logic [15:0] bp_cfg_reg_dcache_mode_gp  = 16'h0043;
  localparam logic [15:0] bp_cfg_reg_cce_mode_gp     = 16'h0081;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'h0,
    e_cce_mem_wr    = 4'h1,
    e_cce_mem_uc_rd = 4'h2,
    e_cce_mem_uc_wr = 4'h3
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_size_1 = 3'b000,
    e_mem_size_2 = 3'b001,
    e_mem_size_4 = 3'b010,
    e_mem_size_8 = 3'b011
  } bp_mem_size_e;

  typedef enum logic [1:0] {
    e_cce_mode_uncached = 2'd0,
    e_cce_mode_normal   = 2'd1
  } bp_cce_mode_e;

  typedef enum logic [1:0] {
    e_lce_mode_uncached = 2'd0,
    e_lce_mode_normal   = 2'd1,
    e_lce_mode_nonspec  = 2'd2
  } bp_lce_mode_e;

  typedef struct packed {
    logic [7:0]                payload;
    bp_mem_size_e              size;
    logic [paddr_width_gp-1:0] addr;
    bp_cce_mem_cmd_type_e      msg_type;
  } bp_cce_mem_msg_header_s;

  typedef struct packed {
    bp_cce_mem_msg_header_s       header;
    logic [cce_data_width_gp-1:0] data;
  } bp_cce_mem_msg_s;

  localparam int unsigned cce_mem_msg_width_gp = $bits(bp_cce_mem_msg_s);

  typedef enum logic [3:0] {
    StIdle,
    StFreeze,
    StUcFetch,
    StUcWr,
    StVfyFetch,
    StVfyRd,
    StCceMode,
    StIcacheMode,
    StDcacheMode,
    StNpc,
    StUnfreeze,
    StDone
  } bp_cfg_loader_state_e;

  typedef enum logic [1:0] {
    StCmdIdle,
    StCmdIssue,
    StCmdWait
  } bp_cfg_issue_state_e;

endpackage

// File: rtl/bp_cfg_loader_issue.sv
// Single-outstanding ISSUE/WAIT handshake unit: latches one cfg access on go_i,
// presents it until accepted, then consumes the response and pulses done_o.
module bp_cfg_loader_issue
  import bp_cfg_loader_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         go_i,
  input  logic                         wr_i,
  input  logic [15:0]                  addr_i,
  input  logic [cce_data_width_gp-1:0] data_i,
  output logic                         done_o,
  output logic [cce_data_width_gp-1:0] resp_data_o,
  output bp_cce_mem_msg_s              mem_cmd_o,
  output logic                         mem_cmd_v_o,
  input  logic                         mem_cmd_ready_and_i,
  input  bp_cce_mem_msg_s              mem_resp_i,
  input  logic                         mem_resp_v_i,
  output logic                         mem_resp_yumi_o
);

  bp_cfg_issue_state_e state_q, state_d;
  bp_cce_mem_msg_s     cmd_q, cmd_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StCmdIdle;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cmd_d           = cmd_q;
    mem_cmd_v_o     = 1'b0;
    mem_resp_yumi_o = 1'b0;
    done_o          = 1'b0;
    unique case (state_q)
      StCmdIdle: begin
        if (go_i) begin
          if (wr_i) cmd_d.header.msg_type = e_cce_mem_uc_wr;
          else      cmd_d.header.msg_type = e_cce_mem_uc_rd;
          cmd_d.header.addr    = paddr_width_gp'(addr_i);
          cmd_d.header.size    = e_mem_size_8;
          cmd_d.header.payload = '0;
          cmd_d.data           = data_i;
          state_d              = StCmdIssue;
        end
      end
      StCmdIssue: begin
        mem_cmd_v_o = 1'b1;
        if (mem_cmd_ready_and_i) state_d = StCmdWait;
      end
      StCmdWait: begin
        mem_resp_yumi_o = mem_resp_v_i;
        if (mem_resp_v_i) begin
          done_o  = 1'b1;
          state_d = StCmdIdle;
        end
      end
      default: state_d = StCmdIdle;
    endcase
  end

  assign mem_cmd_o   = cmd_q;
  assign resp_data_o = mem_resp_i.data;

  // A response with nothing outstanding is a slave protocol violation.
  resp_only_in_wait: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    mem_resp_v_i |-> (state_q == StCmdWait));

  resp_type_match: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (mem_resp_v_i && state_q == StCmdWait)
      |-> (mem_resp_i.header.msg_type == cmd_q.header.msg_type));

endmodule

// File: rtl/bp_cfg_loader.sv
// Power-on boot sequencer: freezes the core, loads (and optionally verifies) CCE
// microcode from ROM, programs cache/CCE modes and the boot NPC, then unfreezes.
module bp_cfg_loader
  import bp_cfg_loader_pkg::*;
#(
  parameter int unsigned ucode_len_p = 256,
  parameter logic [63:0] npc_boot_p  = 64'h0000_0000_8000_0000,
  parameter bit          verify_p    = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          start_i,
  output logic                          ucode_v_o,
  output logic [cce_pc_width_gp-1:0]    ucode_addr_o,
  input  logic [cce_instr_width_gp-1:0] ucode_data_i,
  output bp_cce_mem_msg_s               mem_cmd_o,
  output logic                          mem_cmd_v_o,
  input  logic                          mem_cmd_ready_and_i,
  input  bp_cce_mem_msg_s               mem_resp_i,
  input  logic                          mem_resp_v_i,
  output logic                          mem_resp_yumi_o,
  output logic                          done_o,
  output logic                          error_o
);

  // One extra bit so a full 2^pc_width load does not wrap the counter.
  localparam int unsigned idx_width_lp = cce_pc_width_gp + 1;
  localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(ucode_len_p - 1);

  bp_cfg_loader_state_e            state_q, state_d;
  logic [idx_width_lp-1:0]         index_q, index_d;
  logic [cce_instr_width_gp-1:0]   data_q, data_d;
  logic                            issued_q, issued_d;
  logic                            error_q, error_d;

  logic                            go, wr, cmd_done, cmd_state, last;
  logic [15:0]                     addr, ucode_cfg_addr;
  logic [cce_data_width_gp-1:0]    wdata, resp_data;
  logic                            unused_resp_hi;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= StIdle;
      index_q  <= '0;
      data_q   <= '0;
      issued_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      data_q   <= data_d;
      issued_q <= issued_d;
      error_q  <= error_d;
    end
  end

  assign last           = (index_q == last_idx_lp);
  assign ucode_cfg_addr = bp_cfg_ucode_base_gp + 16'(index_q);
  assign ucode_addr_o   = index_q[cce_pc_width_gp-1:0];
  assign cmd_state      = state_q inside {StFreeze, StUcWr, StVfyRd, StCceMode, StIcacheMode,
                                          StDcacheMode, StNpc, StUnfreeze};

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    data_d    = data_q;
    issued_d  = issued_q;
    error_d   = error_q;
    go        = 1'b0;
    wr        = 1'b1;
    addr      = '0;
    wdata     = '0;
    ucode_v_o = 1'b0;
    unique case (state_q)
      StIdle: if (start_i) state_d = StFreeze;
      StFreeze: begin
        addr  = bp_cfg_reg_freeze_gp;
        wdata = 64'd1;
        if (cmd_done) state_d = StUcFetch;
      end
      StUcFetch: begin
        ucode_v_o = 1'b1;
        state_d   = StUcWr;
      end
      StUcWr: begin
        addr  = ucode_cfg_addr;
        wdata = 64'(ucode_data_i);
        if (!issued_q) data_d = ucode_data_i;
        if (cmd_done) begin
          if (last) begin
            index_d = '0;
            if (verify_p) state_d = StVfyFetch;
            else          state_d = StCceMode;
          end else begin
            index_d = index_q + 1'b1;
            state_d = StUcFetch;
          end
        end
      end
      StVfyFetch: begin
        ucode_v_o = 1'b1;
        state_d   = StVfyRd;
      end
      StVfyRd: begin
        wr   = 1'b0;
        addr = ucode_cfg_addr;
        if (!issued_q) data_d = ucode_data_i;
        if (cmd_done) begin
          // A mismatch is only flagged; the boot proceeds regardless.
          if (resp_data[cce_instr_width_gp-1:0] != data_q) error_d = 1'b1;
          if (last) begin
            index_d = '0;
            state_d = StCceMode;
          end else begin
            index_d = index_q + 1'b1;
            state_d = StVfyFetch;
          end
        end
      end
      StCceMode: begin
        addr  = bp_cfg_reg_cce_mode_gp;
        wdata = 64'(e_cce_mode_normal);
        if (cmd_done) state_d = StIcacheMode;
      end
      StIcacheMode: begin
        addr  = bp_cfg_reg_icache_mode_gp;
        wdata = 64'(e_lce_mode_normal);
        if (cmd_done) state_d = StDcacheMode;
      end
      StDcacheMode: begin
        addr  = bp_cfg_reg_dcache_mode_gp;
        wdata = 64'(e_lce_mode_normal);
        if (cmd_done) state_d = StNpc;
      end
      StNpc: begin
        addr  = bp_cfg_reg_npc_gp;
        wdata = 64'(npc_boot_p[vaddr_width_gp-1:0]);
        if (cmd_done) state_d = StUnfreeze;
      end
      StUnfreeze: begin
        addr  = bp_cfg_reg_freeze_gp;
        wdata = 64'd0;
        if (cmd_done) state_d = StDone;
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
    // Exactly one go per command state; re-armed when the access completes.
    if (cmd_state) begin
      go       = !issued_q;
      issued_d = !cmd_done;
    end
  end

  bp_cfg_loader_issue u_issue (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .go_i                (go),
    .wr_i                (wr),
    .addr_i              (addr),
    .data_i              (wdata),
    .done_o              (cmd_done),
    .resp_data_o         (resp_data),
    .mem_cmd_o           (mem_cmd_o),
    .mem_cmd_v_o         (mem_cmd_v_o),
    .mem_cmd_ready_and_i (mem_cmd_ready_and_i),
    .mem_resp_i          (mem_resp_i),
    .mem_resp_v_i        (mem_resp_v_i),
    .mem_resp_yumi_o     (mem_resp_yumi_o)
  );

  assign unused_resp_hi = ^resp_data[cce_data_width_gp-1:cce_instr_width_gp];
  assign done_o         = (state_q == StDone);
  assign error_o        = error_q;

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Scoreboard bench: two loader instances (4 words + verify, 1 word no verify) against
// behavioural cfg slaves with randomised ready/response delay.
module tb_bp_cfg_loader;
  import bp_cfg_loader_pkg::*;

  typedef struct {
    bp_cce_mem_cmd_type_e t;
    logic [39:0]          addr;
    logic [63:0]          data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b, start_a, start_b;
  logic a_ucode_v, b_ucode_v, a_cmd_v, b_cmd_v, a_cmd_ready, b_cmd_ready;
  logic a_resp_v, b_resp_v, a_yumi, b_yumi, a_done, b_done, a_error, b_error;
  logic [7:0]  a_ucode_addr, b_ucode_addr;
  logic [31:0] a_ucode_data, b_ucode_data;
  bp_cce_mem_msg_s a_cmd, b_cmd, a_resp, b_resp;

  int n_chk = 0, n_fail = 0;
  exp_t exp_a[$], exp_b[$];

  bp_cfg_loader #(.ucode_len_p(4), .verify_p(1'b1)) dut_a (
    .clk_i(clk), .reset_n_i(reset_a), .start_i(start_a),
    .ucode_v_o(a_ucode_v), .ucode_addr_o(a_ucode_addr), .ucode_data_i(a_ucode_data),
    .mem_cmd_o(a_cmd), .mem_cmd_v_o(a_cmd_v), .mem_cmd_ready_and_i(a_cmd_ready),
    .mem_resp_i(a_resp), .mem_resp_v_i(a_resp_v), .mem_resp_yumi_o(a_yumi),
    .done_o(a_done), .error_o(a_error)
  );

  bp_cfg_loader #(.ucode_len_p(1), .verify_p(1'b0)) dut_b (
    .clk_i(clk), .reset_n_i(reset_b), .start_i(start_b),
    .ucode_v_o(b_ucode_v), .ucode_addr_o(b_ucode_addr), .ucode_data_i(b_ucode_data),
    .mem_cmd_o(b_cmd), .mem_cmd_v_o(b_cmd_v), .mem_cmd_ready_and_i(b_cmd_ready),
    .mem_resp_i(b_resp), .mem_resp_v_i(b_resp_v), .mem_resp_yumi_o(b_yumi),
    .done_o(b_done), .error_o(b_error)
  );

  // Synchronous ROMs: word i = 0x100 + i.
  always @(posedge clk) begin
    if (a_ucode_v) a_ucode_data <= 32'h100 + 32'(a_ucode_addr);
    if (b_ucode_v) b_ucode_data <= 32'h100 + 32'(b_ucode_addr);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit sel, input bp_cce_mem_cmd_type_e t, input logic [15:0] a,
                          input logic [63:0] d);
    exp_t e;
    e.t = t; e.addr = 40'(a); e.data = d;
    if (sel) exp_b.push_back(e);
    else     exp_a.push_back(e);
  endtask

  // Reference boot trace derived directly from the sequence description.
  task automatic push_trace(input bit sel, input int len, input bit vfy);
    logic [63:0] npc;
    npc = 64'h0000_0000_8000_0000 & ((64'd1 << vaddr_width_gp) - 64'd1);
    push_exp(sel, e_cce_mem_uc_wr, 16'h0008, 64'd1);
    for (int i = 0; i < len; i++) push_exp(sel, e_cce_mem_uc_wr, 16'(16'h8000 + i), 64'(256 + i));
    if (vfy) for (int i = 0; i < len; i++) push_exp(sel, e_cce_mem_uc_rd, 16'(16'h8000 + i), 64'd0);
    push_exp(sel, e_cce_mem_uc_wr, 16'h0081, 64'd1);
    push_exp(sel, e_cce_mem_uc_wr, 16'h0022, 64'd1);
    push_exp(sel, e_cce_mem_uc_wr, 16'h0043, 64'd1);
    push_exp(sel, e_cce_mem_uc_wr, 16'h0010, npc);
    push_exp(sel, e_cce_mem_uc_wr, 16'h0008, 64'd0);
  endtask

  function automatic logic [127:0] cmd_bits(input bp_cce_mem_msg_s c);
    return 128'({c.header.size, c.header.payload, c.header.msg_type, c.header.addr, c.data});
  endfunction

  function automatic logic [127:0] exp_bits(input exp_t e);
    return 128'({e_mem_size_8, 8'h00, e.t, e.addr, e.data});
  endfunction

  // ---------------- slave / monitor for instance A ----------------
  int unsigned ready_pct = 100, max_delay = 0, a_cnt;
  bit corrupt = 1'b0;
  bit a_acc_p, a_yumi_p, a_hold_v, a_outst, a_bad_p, a_err_exp;
  int n_acc_a = 0;
  bp_cce_mem_msg_s a_acc_cmd, a_hold_cmd, a_resp_msg;
  logic [63:0] cfg_mem [logic [39:0]];

  always @(negedge clk) begin
    exp_t e;
    if (!reset_a) begin
      a_acc_p = 0; a_yumi_p = 0; a_hold_v = 0; a_outst = 0; a_bad_p = 0; a_err_exp = 0;
      a_resp_v = 1'b0; a_cmd_ready = 1'b0; a_resp = '0;
    end else begin
      if (a_yumi_p) begin
        a_resp_v = 1'b0;
        a_outst  = 1'b0;
        if (a_bad_p) a_err_exp = 1'b1;
        check("a_error_o", 128'(a_error), 128'(a_err_exp));
      end
      if (a_acc_p) begin
        check("a_one_outstanding", 128'(a_outst), 128'd0);
        n_acc_a++;
        if (exp_a.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL a_extra_cmd: got addr %0h, expected no command", a_acc_cmd.header.addr);
        end else begin
          e = exp_a.pop_front();
          check("a_cmd", cmd_bits(a_acc_cmd), exp_bits(e));
        end
        a_resp_msg = '0;
        a_resp_msg.header = a_acc_cmd.header;
        a_bad_p = 1'b0;
        if (a_acc_cmd.header.msg_type == e_cce_mem_uc_wr)
          cfg_mem[a_acc_cmd.header.addr] = a_acc_cmd.data;
        else if (corrupt && a_acc_cmd.header.addr == 40'h8002) begin
          a_resp_msg.data = 64'hDEAD;
          a_bad_p = 1'b1;
        end else if (cfg_mem.exists(a_acc_cmd.header.addr))
          a_resp_msg.data = cfg_mem[a_acc_cmd.header.addr];
        a_outst = 1'b1;
        a_cnt   = $urandom_range(max_delay, 0);
      end
      if (a_outst && !a_resp_v) begin
        if (a_cnt == 0) begin
          a_resp_v = 1'b1;
          a_resp   = a_resp_msg;
        end else a_cnt--;
      end
      a_cmd_ready = ($urandom_range(99, 0) < ready_pct);
      #1;
      if (a_hold_v) check("a_cmd_stable", {a_cmd_v, cmd_bits(a_cmd)}, {1'b1, cmd_bits(a_hold_cmd)});
      check("a_v_yumi_excl", 128'(a_cmd_v & a_yumi), 128'd0);
      check("a_quiet_in_done", 128'(a_done & (a_cmd_v | a_yumi | a_ucode_v)), 128'd0);
      a_acc_p    = a_cmd_v & a_cmd_ready;
      a_acc_cmd  = a_cmd;
      a_yumi_p   = a_yumi;
      a_hold_v   = a_cmd_v & ~a_cmd_ready;
      a_hold_cmd = a_cmd;
    end
  end

  // ---------------- zero-wait slave / monitor for instance B ----------------
  bit b_acc_p, b_yumi_p;
  int n_acc_b = 0;
  bp_cce_mem_msg_s b_acc_cmd;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_b) begin
      b_acc_p = 0; b_yumi_p = 0; b_resp_v = 1'b0; b_resp = '0; b_cmd_ready = 1'b0;
    end else begin
      if (b_yumi_p) begin
        b_resp_v = 1'b0;
        if (n_acc_b == 7) check("b_done_after_last_yumi", 128'(b_done), 128'd1);
      end
      if (b_acc_p) begin
        if (exp_b.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL b_extra_cmd: got addr %0h, expected no command", b_acc_cmd.header.addr);
        end else begin
          e = exp_b.pop_front();
          check("b_cmd", cmd_bits(b_acc_cmd), exp_bits(e));
        end
        n_acc_b++;
        b_resp = '0;
        b_resp.header = b_acc_cmd.header;
        b_resp_v = 1'b1;
      end
      b_cmd_ready = 1'b1;
      #1;
      if (b_yumi && n_acc_b == 7) check("b_done_before_last_yumi", 128'(b_done), 128'd0);
      check("b_v_yumi_excl", 128'(b_cmd_v & b_yumi), 128'd0);
      b_acc_p   = b_cmd_v & b_cmd_ready;
      b_acc_cmd = b_cmd;
      b_yumi_p  = b_yumi;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_a_quiet(input string name);
    check(name, {a_ucode_v, a_cmd_v, a_yumi, a_done, a_error}, 128'd0);
  endtask

  task automatic reset_dut_a();
    @(negedge clk); #2 reset_a = 1'b0;
    #1 check_a_quiet("a_outputs_in_reset");
    repeat (2) @(negedge clk);
    exp_a.delete();
    #2 reset_a = 1'b1;
  endtask

  task automatic pulse_start_a();
    @(negedge clk); #2 start_a = 1'b1;
    @(negedge clk); #2 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input bit exp_err);
    int cyc = 0;
    while (!a_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    #2;
    check("a_done_o", 128'(a_done), 128'd1);
    check("a_error_final", 128'(a_error), 128'(exp_err));
    check("a_trace_consumed", 128'(exp_a.size()), 128'd0);
  endtask

  initial begin
    int cyc;
    bit hit;
    reset_a = 1'b0; reset_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    #1;
    check_a_quiet("a_reset_state");
    check("b_reset_state", {b_ucode_v, b_cmd_v, b_yumi, b_done, b_error}, 128'd0);
    repeat (3) @(negedge clk);
    #2 reset_a = 1'b1; reset_b = 1'b1;

    // One word, no verify: exactly seven commands.
    push_trace(1'b1, 1, 1'b0);
    @(negedge clk); #2 start_b = 1'b1;
    @(negedge clk); #2 start_b = 1'b0;
    cyc = 0;
    while (!b_done && cyc < 1000) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    #2;
    check("b_done_o", 128'(b_done), 128'd1);
    check("b_cmd_count", 128'(n_acc_b), 128'd7);
    check("b_error_o", 128'(b_error), 128'd0);

    // Zero-wait slave, clean verify.
    push_trace(1'b0, 4, 1'b1);
    pulse_start_a();
    wait_done_a(1'b0);

    // Corrupted read-back of word 2.
    reset_dut_a();
    corrupt = 1'b1;
    push_trace(1'b0, 4, 1'b1);
    pulse_start_a();
    wait_done_a(1'b1);
    corrupt = 1'b0;

    // Random back-pressure and response latency.
    reset_dut_a();
    ready_pct = 30; max_delay = 5;
    push_trace(1'b0, 4, 1'b1);
    pulse_start_a();
    wait_done_a(1'b0);

    // Reset while the third microcode write is being issued, then restart.
    reset_dut_a();
    push_trace(1'b0, 4, 1'b1);
    pulse_start_a();
    hit = 1'b0; cyc = 0;
    while (!hit && cyc < 3000) begin
      @(negedge clk); #1;
      hit = a_cmd_v && a_cmd.header.msg_type == e_cce_mem_uc_wr && a_cmd.header.addr == 40'h8002;
      cyc++;
    end
    check("a_reached_third_uc_wr", 128'(hit), 128'd1);
    #1 reset_a = 1'b0;
    #1 check_a_quiet("a_outputs_mid_reset");
    repeat (3) @(negedge clk);
    #1 check_a_quiet("a_outputs_held_reset");
    exp_a.delete();
    #1 reset_a = 1'b1;
    push_trace(1'b0, 4, 1'b1);
    pulse_start_a();
    wait_done_a(1'b0);

    // start held high in DONE must not restart anything.
    cyc = n_acc_a;
    @(negedge clk); #2 start_a = 1'b1;
    repeat (50) @(negedge clk);
    #2;
    check("a_done_sticky", 128'(a_done), 128'd1);
    check("a_no_restart", 128'(n_acc_a), 128'(cyc));
    check("a_no_yumi_in_done", 128'(a_yumi), 128'd0);
    start_a = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
